// File: rtl/axis_gate_encoder_pkg.sv
// Shared definitions for the gate-controller stream encoder: the 128-bit word layout and a packing helper.
package gate_pkg;

  localparam int WORD_W    = 128;
  localparam int CNT_LSB   = 0;
  localparam int CNT_W     = 64;
  localparam int POFF_LSB  = 64;
  localparam int POFF_W    = 32;
  localparam int LEVEL_LSB = 96;
  localparam int LEVEL_W   = 16;
  localparam int PAD_LSB   = 112;
  localparam int PAD_W     = 16;

  typedef logic [WORD_W-1:0] gate_word_t;

  // Pad field is always zero so a replaying controller can ignore it.
  function automatic gate_word_t pack_word(input logic [POFF_W-1:0]  poff,
                                           input logic [LEVEL_W-1:0] level,
                                           input logic [CNT_W-1:0]   cnt);
    gate_word_t w;
    w = '0;
    w[CNT_LSB   +: CNT_W]   = cnt;
    w[POFF_LSB  +: POFF_W]  = poff;
    w[LEVEL_LSB +: LEVEL_W] = level;
    w[PAD_LSB   +: PAD_W]   = '0;
    return w;
  endfunction

endpackage

// File: rtl/axis_gate_encoder_fifo.sv
// Synchronous first-word-fall-through FIFO; a write is accepted when full only if a read happens in the same cycle.
module axis_gate_encoder_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_rd, do_wr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_rd   = rd_en_i & ~empty_o;
  assign do_wr   = wr_en_i & (~full_o | do_rd);

  // Output is forced to zero while empty so nothing stale is ever visible downstream.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
    else if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_gate_encoder.sv
// Run-length encoder: one 128-bit AXIS word per constant poff/level run, count = run length - 1.
// Optional mid-run flush input enabled by defining AXIS_GATE_ENCODER_FLUSH_EN.
module axis_gate_encoder
  import gate_pkg::*;
#(
  parameter int CNTR_WIDTH = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                enbl,
  input  logic [POFF_W-1:0]   poff,
  input  logic [LEVEL_W-1:0]  level,
`ifdef AXIS_GATE_ENCODER_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                m_axis_tready,
  output logic [WORD_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                overflow,
  output logic                busy
);

  logic                  open_q, open_d;
  logic [POFF_W-1:0]     cur_poff_q, cur_poff_d;
  logic [LEVEL_W-1:0]    cur_level_q, cur_level_d;
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, split, flush_req;
  logic                  fifo_full, fifo_empty;
  gate_word_t            push_word;

`ifdef AXIS_GATE_ENCODER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign split = (poff != cur_poff_q) | (level != cur_level_q) | (&cnt_q) | flush_req;

  // A closed run always restarts on the current sample; an open run either grows or is pushed and reloaded.
  always_comb begin
    open_d      = open_q;
    cur_poff_d  = cur_poff_q;
    cur_level_d = cur_level_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    if (enbl) begin
      if (!open_q || split) begin
        push        = open_q;
        open_d      = 1'b1;
        cur_poff_d  = poff;
        cur_level_d = level;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CNTR_WIDTH'(1);
      end
    end else if (open_q) begin
      push   = 1'b1;
      open_d = 1'b0;
    end
  end

  assign push_word = pack_word(cur_poff_q, cur_level_q, CNT_W'(cnt_q));
  assign pop       = m_axis_tvalid & m_axis_tready;

  // A full FIFO still takes the word if the head leaves in the same cycle.
  assign overflow_d = overflow_q | (push & fifo_full & ~pop);

  always_ff @(posedge aclk) begin
    if (areset) begin
      open_q      <= 1'b0;
      cur_poff_q  <= '0;
      cur_level_q <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      open_q      <= open_d;
      cur_poff_q  <= cur_poff_d;
      cur_level_q <= cur_level_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  axis_gate_encoder_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (aclk),
    .rst_i    (areset),
    .wr_en_i  (push),
    .wr_data_i(push_word),
    .rd_en_i  (m_axis_tready),
    .rd_data_o(m_axis_tdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign overflow      = overflow_q;
  assign busy          = open_q | ~fifo_empty;

endmodule
